mdu_sequencer: RTL and testbench
================================

Name: mdu_sequencer

Overview:
- Iterative unsigned multiply/divide sequencer (MUL, MULHU, DIVU, REMU) for the single-cycle core.
- Has no adder of its own. Each cycle it drives the shared 32-bit ALU's alu_op/A/B inputs and consumes its C output: ADD for shift-add multiply, SUB for restoring divide.
- Sits between decode/writeback and the ALU mux. The core stalls while busy is high.

Parameters:
- OP_ADD, 4'b0000, ALU opcode driven during multiply iterations
- OP_SUB, 4'b0001, ALU opcode driven during divide iterations
- ITER, 32, iterations per operation; equals the operand width, fixed at 32

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous abort; returns the block to IDLE
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_op  in  2  00 MUL, 01 MULHU, 10 DIVU, 11 REMU
- req_a  in  32  multiplicand / dividend
- req_b  in  32  multiplier / divisor
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  32  result
- busy  out  1  high in RUN and DONE
- alu_op  out  4  to shared ALU
- alu_a  out  32  to shared ALU
- alu_b  out  32  to shared ALU
- alu_c  in  32  ALU result, combinational in the same cycle

Behaviour:
- Single clock. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, req_ready=1, rsp_valid=0, rsp_data=0, busy=0, alu_op=OP_ADD, alu_a=0, alu_b=0. All internal registers are 0.
- States: IDLE, RUN, DONE.
- req_ready = (state==IDLE) and not flush.
- A request is accepted on the edge where req_valid and req_ready are both high. On acceptance the block latches op, A, B and clears the 5-bit iteration counter.
- IDLE transitions on acceptance:
  - DIVU/REMU with req_b==0: go directly to DONE. rsp_data = 0xFFFFFFFF for DIVU, req_a for REMU.
  - All other requests: go to RUN.
- Multiply in RUN:
  - Registers: hi=0, lo=multiplier, m=multiplicand.
  - Each cycle drive alu_op=OP_ADD, alu_a=hi, alu_b=(lo[0] ? m : 0).
  - carry = (alu_c < hi), unsigned compare.
  - Update {hi,lo} = {carry, alu_c, lo} >> 1.
- Divide in RUN:
  - Registers: r=0, q=dividend, d=divisor.
  - rs = {r[30:0], q[31]}; msb = r[31].
  - Each cycle drive alu_op=OP_SUB, alu_a=rs, alu_b=d.
  - If msb or rs >= d (unsigned): r=alu_c, q={q[30:0],1}. Otherwise r=rs, q={q[30:0],0}.
- The counter increments once per RUN cycle. After the 32nd RUN cycle (counter==31) the block loads rsp_data and goes to DONE.
- Result selection: MUL=lo, MULHU=hi, DIVU=q, REMU=r.
- Latency: rsp_valid rises 33 cycles after the accept edge (32 RUN cycles), or 1 cycle after accept for divide-by-zero.
- DONE:
  - rsp_valid=1; rsp_data is held stable.
  - On rsp_ready, go to IDLE. A new request may be accepted on the edge after that.
  - rsp_ready low holds DONE indefinitely; no result is lost.
- ALU drive outside RUN: alu_op=OP_ADD, alu_a=0, alu_b=0. The ALU mux selects the core when busy is low.
- flush has priority over every transition. From RUN or DONE it returns to IDLE next edge, clears rsp_valid, and discards any pending or in-progress result. A request presented in the same cycle as flush is not accepted.
- rst_n assertion mid-operation immediately forces all reset values. No response is produced for the aborted operation.
- rsp_ready while not in DONE is ignored.
- req_valid while busy is ignored: req_ready is low, so there is no acceptance.

Test Plan:
- MUL 7*6, rsp_ready=1 -> rsp_data=42, rsp_valid exactly 33 cycles after accept, alu_op=0000 during all 32 RUN cycles.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MUL same operands -> 0x00000001 (checks carry path).
- DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 0x80000000/1 -> 0x80000000 (checks msb path); alu_op=0001 during RUN.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with rsp_valid 1 cycle after accept.
- Back-pressure: MUL 3*5 with rsp_ready=0 for 10 cycles after rsp_valid -> rsp_valid and rsp_data=15 held; req_ready=0 throughout; IDLE the edge after rsp_ready=1.
- flush at RUN cycle 10 -> IDLE next edge, rsp_valid never asserted; a following DIVU 9/3 -> 3. rst_n low at RUN cycle 20 -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mdu_sequencer.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU sequencer. It borrows the core's shared
// 32-bit ALU for every add or subtract step, so it contains no adder of its own.
module mdu_sequencer #(
  parameter logic [3:0] OP_ADD = 4'b0000,
  parameter logic [3:0] OP_SUB = 4'b0001,
  parameter int         ITER   = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        busy,
  output logic [3:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_c
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MUL   = 2'b00,
    MULHU = 2'b01,
    DIVU  = 2'b10,
    REMU  = 2'b11
  } mdu_op_e;

  state_e      state_q, state_d;
  mdu_op_e     op_q, op_d;
  // hi holds the product high half or the remainder; lo holds the multiplier or
  // the quotient; m holds the multiplicand or the divisor.
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] m_q, m_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [31:0] rs;
  logic        carry;
  logic        accept;
  logic        last;

  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_data  = rsp_data_q;
  assign rs        = {hi_q[30:0], lo_q[31]};
  assign last      = (cnt_q == 5'(ITER - 1));

  // NOTE: every signal assigned here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    m_d        = m_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    alu_op     = OP_ADD;
    alu_a      = '0;
    alu_b      = '0;
    carry      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = mdu_op_e'(req_op);
          hi_d  = '0;
          cnt_d = '0;
          if (req_op[1]) begin
            lo_d = req_a;
            m_d  = req_b;
          end else begin
            lo_d = req_b;
            m_d  = req_a;
          end
          // Divide by zero bypasses RUN with the architecturally defined result.
          if (req_op[1] && (req_b == 32'd0)) begin
            state_d    = DONE;
            rsp_data_d = req_op[0] ? req_a : 32'hFFFF_FFFF;
          end else begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        cnt_d = cnt_q + 5'd1;
        if (!op_q[1]) begin
          alu_op = OP_ADD;
          alu_a  = hi_q;
          alu_b  = lo_q[0] ? m_q : 32'd0;
          carry  = (alu_c < hi_q);
          hi_d   = {carry, alu_c[31:1]};
          lo_d   = {alu_c[0], lo_q[31:1]};
        end else begin
          alu_op = OP_SUB;
          alu_a  = rs;
          alu_b  = m_q;
          // A set msb means the shifted remainder is 33 bits wide and exceeds d.
          if (hi_q[31] || (rs >= m_q)) begin
            hi_d = alu_c;
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = rs;
            lo_d = {lo_q[30:0], 1'b0};
          end
        end
        if (last) begin
          state_d = DONE;
          unique case (op_q)
            MUL, DIVU:   rsp_data_d = lo_d;
            MULHU, REMU: rsp_data_d = hi_d;
          endcase
        end
      end

      DONE: begin
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase

    if (flush) state_d = IDLE;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= MUL;
      hi_q       <= '0;
      lo_q       <= '0;
      m_q        <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      m_q        <= m_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
    end
  end

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer; a behavioural ALU closes the loop and a
// 64-bit arithmetic model produces the expected results.
module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        busy;
  logic [3:0]  alu_op;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_c;

  int tests_run = 0;
  int fails     = 0;
  logic [31:0] sb_q[$];

  mdu_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_c     (alu_c)
  );

  always #5 clk = ~clk;

  assign alu_c = (alu_op == 4'b0001) ? (alu_a - alu_b) : (alu_a + alu_b);

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    p = {32'd0, a} * {32'd0, b};
    case (op)
      2'b00:   return p[31:0];
      2'b01:   return p[63:32];
      2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, pushes its expected result, waits for rsp_valid and
  // checks latency, ALU opcode during RUN and the result. Leaves DONE only if
  // rsp_ready is high on entry.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input string name);
    int lat;
    int alu_ok;
    logic [3:0] exp_alu;
    logic [31:0] exp;
    exp_alu = op[1] ? 4'b0001 : 4'b0000;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    tests_run++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL %s req_ready: got %b expected 1", name, req_ready);
    end
    tick();
    req_valid = 1'b0;
    sb_q.push_back(model(op, a, b));
    lat = 1; alu_ok = 0;
    while (rsp_valid !== 1'b1 && lat < 100) begin
      if (alu_op === exp_alu) alu_ok++;
      tick();
      lat++;
    end
    tests_run++;
    if (lat != exp_lat) begin
      fails++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    tests_run++;
    if (alu_ok != exp_lat - 1) begin
      fails++; $display("FAIL %s alu_op in RUN: got %0d good cycles expected %0d",
                        name, alu_ok, exp_lat - 1);
    end
    if (rsp_valid === 1'b1) begin
      exp = sb_q.pop_front();
      tests_run++;
      if (rsp_data !== exp) begin
        fails++; $display("FAIL %s rsp_data: got %h expected %h", name, rsp_data, exp);
      end
      tests_run++;
      if ({busy, req_ready} !== 2'b10) begin
        fails++; $display("FAIL %s busy/req_ready in DONE: got %b expected 10", name,
                          {busy, req_ready});
      end
      if (rsp_ready === 1'b1) begin
        tick();
        tests_run++;
        if ({rsp_valid, req_ready, busy, alu_a, alu_b} !== {1'b0, 1'b1, 1'b0, 64'd0}) begin
          fails++; $display("FAIL %s return to IDLE: got v=%b rdy=%b busy=%b a=%h b=%h",
                            name, rsp_valid, req_ready, busy, alu_a, alu_b);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'b00; req_a = '0; req_b = '0;
    #12;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_data, busy, alu_op, alu_a, alu_b} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL reset values: got rdy=%b v=%b d=%h busy=%b op=%h a=%h b=%h",
                        req_ready, rsp_valid, rsp_data, busy, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    run_op(2'b00, 32'd7, 32'd6, 33, "mul_7x6");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhu_max");
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mul_max");
    run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 33, "mulhu_mixed");
  endtask

  task automatic test_div();
    run_op(2'b10, 32'd100, 32'd7, 33, "divu_100_7");
    run_op(2'b11, 32'd100, 32'd7, 33, "remu_100_7");
    run_op(2'b10, 32'h8000_0000, 32'd1, 33, "divu_msb");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 33, "remu_big_div");
    run_op(2'b10, 32'd3, 32'd10, 33, "divu_small");
  endtask

  task automatic test_div_by_zero();
    run_op(2'b10, 32'd5, 32'd0, 1, "divu_by_zero");
    run_op(2'b11, 32'd5, 32'd0, 1, "remu_by_zero");
  endtask

  task automatic test_back_pressure();
    int bad;
    rsp_ready = 1'b0;
    run_op(2'b00, 32'd3, 32'd5, 33, "bp_mul_3x5");
    bad = 0;
    req_op = 2'b10; req_a = 32'd1; req_b = 32'd0; req_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if ({rsp_valid, rsp_data, req_ready, busy} !== {1'b1, 32'd15, 1'b0, 1'b1}) bad++;
    end
    tests_run++;
    if (bad != 0) begin
      fails++; $display("FAIL bp hold: got %0d bad cycles expected 0", bad);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tests_run++;
    if ({rsp_valid, busy, req_ready} !== 3'b001) begin
      fails++; $display("FAIL bp release: got v/busy/rdy=%b expected 001",
                        {rsp_valid, busy, req_ready});
    end
  endtask

  task automatic test_flush();
    int seen;
    req_op = 2'b00; req_a = 32'h0000_1234; req_b = 32'h0000_5678; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    req_op = 2'b10; req_a = 32'd1; req_b = 32'd0; req_valid = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 1'b0) begin
      fails++; $display("FAIL flush req_ready: got %b expected 0", req_ready);
    end
    tick();
    flush = 1'b0; req_valid = 1'b0;
    #1;
    tests_run++;
    if ({busy, rsp_valid, req_ready} !== 3'b001) begin
      fails++; $display("FAIL flush to IDLE: got busy/v/rdy=%b expected 001",
                        {busy, rsp_valid, req_ready});
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1 || busy === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++; $display("FAIL flush discard: got %0d active cycles expected 0", seen);
    end
    run_op(2'b10, 32'd9, 32'd3, 33, "divu_after_flush");
  endtask

  task automatic test_reset_mid_op();
    int seen;
    req_op = 2'b00; req_a = 32'hDEAD_BEEF; req_b = 32'h0000_0FFF; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 19; i++) tick();
    tests_run++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL midrst busy before reset: got %b expected 1", busy);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({req_ready, rsp_valid, rsp_data, busy, alu_op, alu_a, alu_b} !==
        {1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0}) begin
      fails++; $display("FAIL midrst values: got rdy=%b v=%b d=%h busy=%b op=%h a=%h b=%h",
                        req_ready, rsp_valid, rsp_data, busy, alu_op, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid === 1'b1) seen++;
    end
    tests_run++;
    if (seen != 0) begin
      fails++; $display("FAIL midrst no response: got %0d valid cycles expected 0", seen);
    end
    run_op(2'b11, 32'd50, 32'd8, 33, "remu_after_reset");
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_by_zero();
    test_back_pressure();
    test_flush();
    test_reset_mid_op();
    tests_run++;
    if (sb_q.size() != 0) begin
      fails++; $display("FAIL scoreboard drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
